// File: rtl/rotation_scheduler_if.sv
// Control pulses from the button debouncers and the rotation/scan outputs
// towards the char ROM and segment decoder.
interface rotation_scheduler_if #(
    parameter int POS_W = 4
);
    logic             start_pls;
    logic             pause_pls;
    logic             stop_pls;
    logic             step_pls;
    logic             dir;
    logic             load_en;
    logic [POS_W-1:0] load_pos;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] char_idx;
    logic [1:0]       digit_sel;
    logic [3:0]       anode_n;
    logic             running;
    logic             step_done;

    modport master (
        output start_pls, pause_pls, stop_pls, step_pls, dir, load_en, load_pos,
        input  pos, char_idx, digit_sel, anode_n, running, step_done
    );

    modport slave (
        input  start_pls, pause_pls, stop_pls, step_pls, dir, load_en, load_pos,
        output pos, char_idx, digit_sel, anode_n, running, step_done
    );
endinterface

// File: rtl/rotation_scheduler.sv
// Message rotation sequencer (run/pause/stop/step/load) plus 4-digit anode scan.
// Commands act on the next edge, step_done one cycle after an advance; no backpressure.
module rotation_scheduler #(
    parameter int TICKS_PER_STEP = 3125000,
    parameter int CNT_W          = 22,
    parameter int MSG_LEN        = 16,
    parameter int POS_W          = 4,
    parameter int SCAN_TICKS     = 1000
) (
    input  logic                clkdv,
    input  logic                reset,
    rotation_scheduler_if.slave bus
);
    localparam int SCAN_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICKS_PER_STEP - 1);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(MSG_LEN - 1);
    localparam logic [POS_W:0]    LEN_EXT   = (POS_W + 1)'(MSG_LEN);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TICKS - 1);

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [POS_W-1:0]  pos, pos_nxt, pos_adv;
    logic              advance;
    logic              step_done;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        digit_sel;
    logic [POS_W:0]    idx_sum;

    always_comb begin
        pos_adv = pos;
        if (bus.dir) begin
            pos_adv = (pos == '0) ? POS_LAST : pos - POS_W'(1);
        end else begin
            pos_adv = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
        end
    end

    // Fixed command priority: load > stop > pause > start > step. A present but
    // inapplicable higher command still masks the lower ones for that edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pos_nxt   = pos;
        advance   = 1'b0;
        if (bus.load_en) begin
            pos_nxt = ({1'b0, bus.load_pos} < LEN_EXT) ? bus.load_pos : '0;
            cnt_nxt = '0;
        end else if (bus.stop_pls) begin
            state_nxt = ST_STOPPED;
            cnt_nxt   = '0;
        end else if (bus.pause_pls) begin
            if (state == ST_RUNNING) begin
                state_nxt = ST_PAUSED;
            end
        end else if (bus.start_pls && (state != ST_RUNNING)) begin
            state_nxt = ST_RUNNING;
        end else if (state == ST_RUNNING) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                advance = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else if (bus.step_pls) begin
            advance = 1'b1;
        end
        if (advance) begin
            pos_nxt = pos_adv;
        end
    end

    always_ff @(posedge clkdv) begin
        if (reset) begin
            state     <= ST_STOPPED;
            cnt       <= '0;
            pos       <= '0;
            step_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pos       <= pos_nxt;
            step_done <= advance;
        end
    end

    always_ff @(posedge clkdv) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_sel <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_sel <= digit_sel + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    assign idx_sum       = {1'b0, pos} + {{(POS_W - 1){1'b0}}, digit_sel};
    assign bus.char_idx  = (idx_sum >= LEN_EXT) ? POS_W'(idx_sum - LEN_EXT) : idx_sum[POS_W-1:0];
    assign bus.pos       = pos;
    assign bus.digit_sel = digit_sel;
    assign bus.anode_n   = ~(4'b0001 << digit_sel);
    assign bus.running   = (state == ST_RUNNING);
    assign bus.step_done = step_done;
endmodule

// File: tb/tb_rotation_scheduler.sv
// Randomized and directed bench for rotation_scheduler; a cycle-level reference model
// pushes expected outputs into a queue that a monitor checks after every edge.
module tb_rotation_scheduler;
    localparam int T    = 4;
    localparam int SCAN = 2;
    localparam int LEN  = 16;
    localparam int PW   = 4;

    localparam int C_RST = 1;
    localparam int C_STA = 2;
    localparam int C_PAU = 4;
    localparam int C_STP = 8;
    localparam int C_STE = 16;
    localparam int C_LD  = 32;

    localparam int M_STOP  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    typedef struct {
        string          lbl;
        logic [PW-1:0]  pos;
        logic [PW-1:0]  ci;
        logic [1:0]     dg;
        logic [3:0]     an;
        logic           run;
        logic           done;
    } exp_t;

    logic clkdv = 1'b0;
    logic reset = 1'b1;
    always #5 clkdv = ~clkdv;

    rotation_scheduler_if #(.POS_W(PW)) bus();

    rotation_scheduler #(
        .TICKS_PER_STEP(T), .CNT_W(3), .MSG_LEN(LEN), .POS_W(PW), .SCAN_TICKS(SCAN)
    ) dut (
        .clkdv (clkdv),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   cur_dir = 1'b0;

    // Reference model: mode, ticks elapsed towards the next advance, position,
    // and cycles since reset (the scan digit follows directly from that).
    int m_mode = M_STOP;
    int m_elapsed = 0;
    int m_pos = 0;
    int m_cyc = 0;
    bit m_done = 1'b0;

    task automatic model_step(input int cmd, input bit d, input int lp);
        bit adv = 1'b0;
        if ((cmd & C_RST) != 0) begin
            m_mode = M_STOP; m_elapsed = 0; m_pos = 0; m_cyc = 0; m_done = 1'b0;
            return;
        end
        if ((cmd & C_LD) != 0) begin
            m_pos = (lp < LEN) ? lp : 0;
            m_elapsed = 0;
        end else if ((cmd & C_STP) != 0) begin
            m_mode = M_STOP;
            m_elapsed = 0;
        end else if ((cmd & C_PAU) != 0) begin
            if (m_mode == M_RUN) m_mode = M_PAUSE;
        end else if ((cmd & C_STA) != 0 && m_mode != M_RUN) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            m_elapsed++;
            if (m_elapsed == T) begin
                m_elapsed = 0;
                adv = 1'b1;
            end
        end else if ((cmd & C_STE) != 0) begin
            adv = 1'b1;
        end
        if (adv) m_pos = d ? (m_pos + LEN - 1) % LEN : (m_pos + 1) % LEN;
        m_done = adv;
        m_cyc++;
    endtask

    task automatic tick(input string lbl, input int cmd, input int lp = 0);
        exp_t e;
        int dg;
        logic [3:0] one = 4'b0001;
        @(negedge clkdv);
        reset         = ((cmd & C_RST) != 0);
        bus.start_pls = ((cmd & C_STA) != 0);
        bus.pause_pls = ((cmd & C_PAU) != 0);
        bus.stop_pls  = ((cmd & C_STP) != 0);
        bus.step_pls  = ((cmd & C_STE) != 0);
        bus.load_en   = ((cmd & C_LD) != 0);
        bus.load_pos  = PW'(lp);
        bus.dir       = cur_dir;
        model_step(cmd, cur_dir, lp);
        dg = (m_cyc / SCAN) % 4;
        e.lbl  = lbl;
        e.pos  = PW'(m_pos);
        e.ci   = PW'((m_pos + dg) % LEN);
        e.dg   = 2'(dg);
        e.an   = ~(one << dg);
        e.run  = (m_mode == M_RUN);
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string lbl, input int n);
        for (int i = 0; i < n; i++) tick(lbl, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clkdv);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if ({bus.pos, bus.char_idx, bus.digit_sel, bus.anode_n, bus.running, bus.step_done} !==
                    {e.pos, e.ci, e.dg, e.an, e.run, e.done}) begin
                    n_fail++;
                    $display("FAIL %s t=%0t got pos=%0d ci=%0d dg=%0d an=%b run=%b done=%b, expected pos=%0d ci=%0d dg=%0d an=%b run=%b done=%b",
                             e.lbl, $time, bus.pos, bus.char_idx, bus.digit_sel, bus.anode_n,
                             bus.running, bus.step_done, e.pos, e.ci, e.dg, e.an, e.run, e.done);
                end
            end
        end
    end

    initial begin : driver
        int cmd;
        bus.start_pls = 1'b0; bus.pause_pls = 1'b0; bus.stop_pls = 1'b0;
        bus.step_pls = 1'b0; bus.load_en = 1'b0; bus.load_pos = '0; bus.dir = 1'b0;

        // Free-running advance every T cycles after start
        tick("reset", C_RST); tick("reset", C_RST);
        tick("s1_start", C_STA);
        idle("s1_run", 14);

        // Wrap in both directions
        tick("s2_stop", C_STP);
        tick("s2_load15", C_LD, 15);
        tick("s2_start", C_STA);
        idle("s2_up_wrap", 6);
        cur_dir = 1'b1;
        idle("s2_down_wrap", 8);
        cur_dir = 1'b0;

        // Pause keeps the partial delay count
        tick("s3_stop", C_STP);
        tick("s3_start", C_STA);
        idle("s3_run", 2);
        tick("s3_pause", C_PAU);
        idle("s3_paused", 10);
        tick("s3_resume", C_STA);
        idle("s3_after", 4);

        // Stop on the timeout edge, then single step
        tick("s4_stop", C_STP);
        tick("s4_start", C_STA);
        idle("s4_run", 3);
        tick("s4_stop_at_timeout", C_STP);
        idle("s4_stopped", 2);
        tick("s4_step", C_STE);
        idle("s4_after_step", 2);
        tick("s4_pause_masks_step", C_PAU | C_STE);

        // Step ignored while running; load beats stop
        tick("s5_start", C_STA);
        idle("s5_run", 1);
        tick("s5_step_ignored", C_STE);
        tick("s5_load_stop", C_LD | C_STP, 5);
        idle("s5_after", 6);

        // Scan with wrapping char index, then reset mid-run
        tick("s6_load14", C_LD, 14);
        idle("s6_scan", 10);
        tick("s6_start", C_STA);
        idle("s6_run", 5);
        tick("s6_reset", C_RST);
        idle("s6_post_reset", 4);

        for (int i = 0; i < 600; i++) begin
            cmd = 0;
            if ($urandom_range(0, 9) == 0)   cmd |= C_STA;
            if ($urandom_range(0, 19) == 0)  cmd |= C_PAU;
            if ($urandom_range(0, 29) == 0)  cmd |= C_STP;
            if ($urandom_range(0, 7) == 0)   cmd |= C_STE;
            if ($urandom_range(0, 29) == 0)  cmd |= C_LD;
            if ($urandom_range(0, 199) == 0) cmd |= C_RST;
            if ($urandom_range(0, 19) == 0)  cur_dir = ~cur_dir;
            tick("random", cmd, int'($urandom_range(0, LEN - 1)));
        end

        repeat (3) @(negedge clkdv);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
